// File: rtl/shift_issue_pipe_pkg.sv
// Shared constants and types for the shift issue pipe: datapath width, R-type shift funct codes
// and the decoded shifter control bundle.
package shift_issue_pipe_pkg;

  localparam int unsigned DataW = 32;

  localparam logic [5:0] FUNCT_SLL  = 6'b000000;
  localparam logic [5:0] FUNCT_SRL  = 6'b000010;
  localparam logic [5:0] FUNCT_SRA  = 6'b000011;
  localparam logic [5:0] FUNCT_SLLV = 6'b000100;
  localparam logic [5:0] FUNCT_SRLV = 6'b000110;
  localparam logic [5:0] FUNCT_SRAV = 6'b000111;

  typedef struct packed {
    logic [4:0] sa;
    logic       right;
    logic       arith;
    logic       err;
  } shift_ctrl_t;

endpackage

// File: rtl/shift_issue_pipe_if.sv
// Upstream issue and downstream writeback handshake bundle for the shift issue pipe.
interface shift_issue_pipe_if;
  import shift_issue_pipe_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [5:0]       funct;
  logic [4:0]       shamt;
  logic [DataW-1:0] rs_val;
  logic [DataW-1:0] rt_val;
  logic [4:0]       dst;
  logic             out_valid;
  logic             out_ready;
  logic [DataW-1:0] out_data;
  logic [4:0]       out_dst;
  logic             out_err;

  modport master (
    output in_valid, funct, shamt, rs_val, rt_val, dst, out_ready,
    input  in_ready, out_valid, out_data, out_dst, out_err
  );

  modport slave (
    input  in_valid, funct, shamt, rs_val, rt_val, dst, out_ready,
    output in_ready, out_valid, out_data, out_dst, out_err
  );

endinterface

// File: rtl/SHIFTER_32.sv
// 32-bit barrel shifter: left logical, right logical or right arithmetic by Sa.
module SHIFTER_32 (
  input  logic [31:0] X,
  input  logic [4:0]  Sa,
  input  logic        Arith,
  input  logic        Right,
  output logic [31:0] Sh
);

  always_comb begin
    if (!Right) begin
      Sh = X << Sa;
    end else if (Arith) begin
      Sh = 32'($signed(X) >>> Sa);
    end else begin
      Sh = X >> Sa;
    end
  end

endmodule

// File: rtl/shift_issue_pipe_decode.sv
// Combinational decode of an R-type shift funct into shifter controls; non-shifts flag err.
module shift_decode
  import shift_issue_pipe_pkg::*;
(
  input  logic [5:0]  funct,
  input  logic [4:0]  shamt,
  input  logic [4:0]  rs_sa,
  output shift_ctrl_t ctrl
);

  always_comb begin
    ctrl = '0;
    case (funct)
      FUNCT_SLL:  ctrl.sa = shamt;
      FUNCT_SRL:  begin ctrl.sa = shamt; ctrl.right = 1'b1; end
      FUNCT_SRA:  begin ctrl.sa = shamt; ctrl.right = 1'b1; ctrl.arith = 1'b1; end
      FUNCT_SLLV: ctrl.sa = rs_sa;
      FUNCT_SRLV: begin ctrl.sa = rs_sa; ctrl.right = 1'b1; end
      FUNCT_SRAV: begin ctrl.sa = rs_sa; ctrl.right = 1'b1; ctrl.arith = 1'b1; end
      default:    ctrl.err = 1'b1;
    endcase
  end

endmodule

// File: rtl/shift_issue_pipe.sv
// Two-stage shift execute pipe: stage 1 holds decoded operands feeding SHIFTER_32, stage 2 holds
// the result for writeback. Valid/ready on both sides; in_ready is combinational from out_ready.
module shift_issue_pipe
  import shift_issue_pipe_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  shift_issue_pipe_if.slave bus,
  output logic [CNT_W-1:0] op_count
);

  shift_ctrl_t      dec_ctrl;
  shift_ctrl_t      ctrl1_q;
  logic             v1_q;
  logic [DataW-1:0] x1_q;
  logic [4:0]       dst1_q;
  logic             v2_q;
  logic [DataW-1:0] data2_q;
  logic [4:0]       dst2_q;
  logic             err2_q;
  logic [CNT_W-1:0] cnt_q;
  logic [DataW-1:0] sh;
  logic             adv1;
  logic             in_xfer;
  logic             out_xfer;
  logic             unused_rs_hi;

  shift_decode u_decode (
    .funct (bus.funct),
    .shamt (bus.shamt),
    .rs_sa (bus.rs_val[4:0]),
    .ctrl  (dec_ctrl)
  );

  SHIFTER_32 u_shifter (
    .X     (x1_q),
    .Sa    (ctrl1_q.sa),
    .Arith (ctrl1_q.arith),
    .Right (ctrl1_q.right),
    .Sh    (sh)
  );

  // Variable shift amounts are modulo 32; the upper rs bits are deliberately dropped.
  assign unused_rs_hi = ^bus.rs_val[DataW-1:5];

  assign adv1         = v1_q & (~v2_q | bus.out_ready);
  assign bus.in_ready = ~v1_q | adv1;
  assign in_xfer      = bus.in_valid & bus.in_ready;
  assign out_xfer     = v2_q & bus.out_ready;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      v1_q    <= 1'b0;
      x1_q    <= '0;
      ctrl1_q <= '0;
      dst1_q  <= '0;
    end else if (in_xfer) begin
      v1_q    <= 1'b1;
      x1_q    <= bus.rt_val;
      ctrl1_q <= dec_ctrl;
      dst1_q  <= bus.dst;
    end else if (adv1) begin
      v1_q    <= 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      v2_q    <= 1'b0;
      data2_q <= '0;
      dst2_q  <= '0;
      err2_q  <= 1'b0;
    end else if (adv1) begin
      v2_q    <= 1'b1;
      data2_q <= ctrl1_q.err ? '0 : sh;
      dst2_q  <= dst1_q;
      err2_q  <= ctrl1_q.err;
    end else if (out_xfer) begin
      v2_q    <= 1'b0;
    end
  end

  // Counts every completed transfer, err ops included; wraps freely.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt_q <= '0;
    end else if (out_xfer) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.out_valid = v2_q;
  assign bus.out_data  = data2_q;
  assign bus.out_dst   = dst2_q;
  assign bus.out_err   = err2_q;
  assign op_count      = cnt_q;

endmodule

// File: tb/tb_shift_issue_pipe.sv
// Bench for shift_issue_pipe: directed scenarios plus random traffic checked against an
// arithmetic reference model and an in-order scoreboard of accepted ops.
module tb_shift_issue_pipe;
  import shift_issue_pipe_pkg::*;

  localparam int unsigned CntW = 4;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  dst;
    logic        err;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [CntW-1:0] op_count;
  int              checks = 0;
  int              errors = 0;
  int              mcnt = 0;
  exp_t            sb[$];

  shift_issue_pipe_if bus ();

  shift_issue_pipe #(.CNT_W(CntW)) dut (
    .Clk      (clk),
    .Rst      (rst),
    .bus      (bus),
    .op_count (op_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: shifts expressed as multiply/divide by powers of two on widened operands.
  function automatic exp_t model(input logic [5:0] f, input logic [4:0] sh,
                                 input logic [31:0] rs, input logic [31:0] rt,
                                 input logic [4:0] d);
    exp_t        e;
    int          amt;
    logic [63:0] w;
    bit          ok, right, arith;
    ok = 1; right = 0; arith = 0;
    amt = int'(sh);
    case (f)
      6'd0: ;
      6'd2: right = 1;
      6'd3: begin right = 1; arith = 1; end
      6'd4: amt = int'(rs % 32);
      6'd6: begin amt = int'(rs % 32); right = 1; end
      6'd7: begin amt = int'(rs % 32); right = 1; arith = 1; end
      default: ok = 0;
    endcase
    if (!ok) w = '0;
    else if (!right) w = {32'b0, rt} * (64'd1 << amt);
    else if (arith) w = {{32{rt[31]}}, rt} >> amt;
    else w = {32'b0, rt} / (64'd1 << amt);
    e.data = w[31:0];
    e.dst  = d;
    e.err  = !ok;
    return e;
  endfunction

  task automatic drive(input bit v, input logic [5:0] f, input logic [4:0] sh,
                       input logic [31:0] rs, input logic [31:0] rt, input logic [4:0] d);
    bus.in_valid = v;
    bus.funct    = f;
    bus.shamt    = sh;
    bus.rs_val   = rs;
    bus.rt_val   = rt;
    bus.dst      = d;
  endtask

  // One clock: check against the model at the falling edge, then step past the rising edge.
  task automatic cycle();
    bit out_x, in_x;
    @(negedge clk);
    chk("in_ready", 64'(bus.in_ready), 64'((sb.size() < 2) || bus.out_ready));
    chk("op_count", 64'(op_count), 64'(mcnt));
    if (sb.size() == 0) begin
      chk("idle_out_valid", 64'(bus.out_valid), 64'(0));
    end else if (bus.out_valid) begin
      chk("out_data", 64'(bus.out_data), 64'(sb[0].data));
      chk("out_dst", 64'(bus.out_dst), 64'(sb[0].dst));
      chk("out_err", 64'(bus.out_err), 64'(sb[0].err));
    end
    out_x = bus.out_valid && bus.out_ready;
    in_x  = bus.in_valid && bus.in_ready;
    if (!rst) begin
      if (out_x && sb.size() > 0) begin
        void'(sb.pop_front());
        mcnt = (mcnt + 1) % (1 << CntW);
      end
      if (in_x) sb.push_back(model(bus.funct, bus.shamt, bus.rs_val, bus.rt_val, bus.dst));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [5:0] ftab [8];
    ftab = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd6, 6'd7, 6'h20, 6'h01};

    rst = 1'b1;
    bus.out_ready = 1'b0;
    drive(0, 6'd0, 5'd0, 32'd0, 32'd0, 5'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_out_data", 64'(bus.out_data), 64'(0));
    chk("rst_out_dst", 64'(bus.out_dst), 64'(0));
    chk("rst_out_err", 64'(bus.out_err), 64'(0));
    chk("rst_op_count", 64'(op_count), 64'(0));
    chk("rst_in_ready", 64'(bus.in_ready), 64'(1));

    // SLL by 31: result appears two edges after acceptance.
    bus.out_ready = 1'b1;
    drive(1, FUNCT_SLL, 5'd31, 32'd0, 32'h0000_0001, 5'd3);
    cycle();
    drive(0, 6'd0, 5'd0, 32'd0, 32'd0, 5'd0);
    chk("sll_not_yet", 64'(bus.out_valid), 64'(0));
    cycle();
    chk("sll_valid", 64'(bus.out_valid), 64'(1));
    chk("sll_data", 64'(bus.out_data), 64'h8000_0000);
    chk("sll_err", 64'(bus.out_err), 64'(0));
    cycle();
    chk("sll_count", 64'(op_count), 64'(1));

    // SRAV then SRLV back to back; rs_val upper bits ignored.
    drive(1, FUNCT_SRAV, 5'd0, 32'hFFFF_FFE4, 32'hF000_0000, 5'd1);
    cycle();
    drive(1, FUNCT_SRLV, 5'd0, 32'hFFFF_FFE4, 32'hF000_0000, 5'd2);
    cycle();
    drive(0, 6'd0, 5'd0, 32'd0, 32'd0, 5'd0);
    chk("srav_data", 64'(bus.out_data), 64'hFF00_0000);
    cycle();
    chk("srlv_valid", 64'(bus.out_valid), 64'(1));
    chk("srlv_data", 64'(bus.out_data), 64'h0F00_0000);
    cycle();

    // Stall: two SRAs fill the pipe, a third waits until out_ready returns.
    bus.out_ready = 1'b0;
    drive(1, FUNCT_SRA, 5'd0, 32'd0, 32'h8000_0000, 5'd5);
    cycle();
    chk("stall_ready1", 64'(bus.in_ready), 64'(1));
    drive(1, FUNCT_SRA, 5'd1, 32'd0, 32'h8000_0000, 5'd6);
    cycle();
    chk("stall_full", 64'(bus.in_ready), 64'(0));
    chk("stall_data0", 64'(bus.out_data), 64'h8000_0000);
    drive(1, FUNCT_SRA, 5'd2, 32'd0, 32'h8000_0000, 5'd7);
    cycle();
    chk("stall_hold", 64'(bus.out_data), 64'h8000_0000);
    chk("stall_hold_dst", 64'(bus.out_dst), 64'(5));
    bus.out_ready = 1'b1;
    cycle();
    drive(0, 6'd0, 5'd0, 32'd0, 32'd0, 5'd0);
    chk("stall_out1", 64'(bus.out_data), 64'hC000_0000);
    chk("stall_dst1", 64'(bus.out_dst), 64'(6));
    cycle();
    chk("stall_out2", 64'(bus.out_data), 64'hE000_0000);
    chk("stall_dst2", 64'(bus.out_dst), 64'(7));
    cycle();
    chk("stall_drained", 64'(bus.out_valid), 64'(0));

    // Non-shift funct (ADD) produces an err op that still counts.
    drive(1, 6'b100000, 5'd3, 32'h1234_5678, 32'hDEAD_BEEF, 5'd9);
    cycle();
    drive(0, 6'd0, 5'd0, 32'd0, 32'd0, 5'd0);
    cycle();
    chk("add_err", 64'(bus.out_err), 64'(1));
    chk("add_data", 64'(bus.out_data), 64'(0));
    chk("add_dst", 64'(bus.out_dst), 64'(9));
    cycle();
    chk("add_count", 64'(op_count), 64'(7));

    // Reset with two ops in flight discards both.
    bus.out_ready = 1'b0;
    drive(1, FUNCT_SRL, 5'd4, 32'd0, 32'hFFFF_0000, 5'd10);
    cycle();
    drive(1, FUNCT_SLL, 5'd4, 32'd0, 32'h0000_FFFF, 5'd11);
    cycle();
    drive(0, 6'd0, 5'd0, 32'd0, 32'd0, 5'd0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    sb.delete();
    mcnt = 0;
    chk("rst2_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst2_op_count", 64'(op_count), 64'(0));
    chk("rst2_in_ready", 64'(bus.in_ready), 64'(1));
    bus.out_ready = 1'b1;
    repeat (3) cycle();

    // Sixteen completions wrap a 4-bit counter back to zero.
    for (int i = 0; i < 16; i++) begin
      drive(1, FUNCT_SLLV, 5'd0, $urandom, $urandom, 5'(i));
      cycle();
    end
    drive(0, 6'd0, 5'd0, 32'd0, 32'd0, 5'd0);
    repeat (3) cycle();
    chk("wrap_count", 64'(op_count), 64'(0));

    // Random traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, ftab[$urandom_range(0, 7)], 5'($urandom), $urandom,
            $urandom, 5'($urandom));
      bus.out_ready = $urandom_range(0, 3) != 0;
      cycle();
    end
    drive(0, 6'd0, 5'd0, 32'd0, 32'd0, 5'd0);
    bus.out_ready = 1'b1;
    repeat (4) cycle();
    chk("final_drained", 64'(bus.out_valid), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shift_issue_pipe.md
Name: shift_issue_pipe

Overview:
- Two-stage execute pipe that decodes MIPS R-type shift instructions, registers the operands and drives the existing 32-bit barrel shifter SHIFTER_32 (ports X, Sa, Arith, Right, Sh).
- Registers the shifter result for the writeback stage.
- Sits between the decode/register-read stage and writeback.
- Valid/ready handshake on both sides, so downstream stalls propagate back without losing operations.

Parameters:
- CNT_W, 16, width of the completed-operation counter.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream presents an instruction.
- in_ready  out  1  stage 1 can accept this cycle.
- funct  in  6  R-type funct field.
- shamt  in  5  instruction shamt field.
- rs_val  in  32  rs register value; [4:0] is the variable shift amount.
- rt_val  in  32  rt register value; the operand to shift.
- dst  in  5  destination register number.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts the result.
- out_data  out  32  shift result.
- out_dst  out  5  destination register of the result.
- out_err  out  1  funct is not a shift; out_data forced to 0.
- op_count  out  CNT_W  number of completed output transfers.

Behaviour:
- Decode in stage 1 capture:
  - 000000 SLL: Sa=shamt, Right=0, Arith=0.
  - 000010 SRL: Sa=shamt, Right=1, Arith=0.
  - 000011 SRA: Sa=shamt, Right=1, Arith=1.
  - 000100 SLLV: Sa=rs_val[4:0], Right=0, Arith=0.
  - 000110 SRLV: Sa=rs_val[4:0], Right=1, Arith=0.
  - 000111 SRAV: Sa=rs_val[4:0], Right=1, Arith=1.
  - Any other funct: err=1, Sa=0, Right=0, Arith=0.
- Stage 1 register (v1, X1=rt_val, Sa1, Right1, Arith1, dst1, err1) drives the shifter combinationally. Its Sh output feeds stage 2.
- Stage 2 register (v2, data2, dst2, err2) drives out_*.
- data2 captures 0 when err1=1, otherwise Sh.
- Handshake:
  - in_ready = !v1 | adv1, where adv1 = v1 & (!v2 | out_ready).
  - Upstream transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
  - Stage 2 loads when adv1. v2 clears when the output transfers and !adv1.
  - v1 loads on an input transfer. v1 clears when adv1 and no new input transfer.
- Latency: 2 cycles from input transfer to out_valid with no stall. Throughput is 1 op/cycle when out_ready is held high.
- Stall: with out_ready=0 the pipe holds 2 ops and in_ready=0. out_data, out_dst and out_err stay stable while out_valid=1 and out_ready=0.
- Simultaneous events:
  - Input transfer and output transfer in the same cycle: both happen; occupancy is unchanged.
  - in_ready is combinational from out_ready. This path is accepted; no skid buffer.
- op_count increments on each output transfer, including err ops. It wraps from 2^CNT_W-1 to 0 with no saturation.
- Reset: v1=0, v2=0, out_valid=0, out_data=0, out_dst=0, out_err=0, op_count=0. in_ready reads 1 in the cycle after reset.
- Reset mid-operation discards all in-flight ops with no output transfer.
- Shift amount is modulo 32 by construction: only 5 bits are used, and rs_val[31:5] is ignored.

Decomposition:
- Shared package holds the funct constants (FUNCT_SLL, FUNCT_SRL, FUNCT_SRA, FUNCT_SLLV, FUNCT_SRLV, FUNCT_SRAV) and the datapath width constant 32.
- One sub-module: shift_decode, a combinational map funct/shamt/rs_val[4:0] -> {Sa, Right, Arith, err}.
- SHIFTER_32 is instantiated unchanged between the two registers.

Test Plan:
- SLL, rt_val=32'h0000_0001, shamt=31, out_ready=1 -> out_data=32'h8000_0000 two cycles after acceptance, out_err=0, op_count=1.
- SRAV, rt_val=32'hF000_0000, rs_val=32'hFFFF_FFE4 (amount 4), then SRLV with the same operands -> 32'hFF00_0000 then 32'h0F00_0000 on consecutive cycles.
- Back-to-back SRA of rt_val=32'h8000_0000 with shamt 0,1,2, with out_ready=0 for 3 cycles:
  - in_ready drops after 2 accepts.
  - out_data holds 32'h8000_0000 stable while stalled.
  - After out_ready=1: outputs 32'h8000_0000, 32'hC000_0000, 32'hE000_0000 in order, with dst preserved.
- funct=6'b100000 (ADD) -> out_err=1, out_data=0, op_count increments.
- Assert Rst with 2 ops in flight -> next cycle out_valid=0, op_count=0, in_ready=1, and no further output from the discarded ops.
- CNT_W=4, 16 completed ops -> op_count wraps to 0.
